// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // Register-file index width (32 architectural registers)
  localparam int REG_IDX_W = 5;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  // Control bits the pipeline loads into a flushed register: every
  // side-effecting control (regwrite, memtoreg, memread, memwrite) cleared.
  localparam logic [3:0] NOP_CTRL = 4'b0000;

  // Bundle of all pipeline-register controls driven by the sequencer
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN      = ctrl_t'(8'b11111_000);
  localparam ctrl_t CTRL_RESET    = ctrl_t'(8'b00000_111);
  localparam ctrl_t CTRL_MEMSTALL = ctrl_t'(8'b00001_001);
  localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b11111_110);
  localparam ctrl_t CTRL_LOADUSE  = ctrl_t'(8'b00111_010);
  localparam ctrl_t CTRL_FAULT    = ctrl_t'(8'b00000_001);

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Hazard inputs from the pipeline and register controls back to it.
// Revision: 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  // Hazard sources (pipeline -> controller)
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic                 ex_memread;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 branch_taken;
  logic                 mem_req;
  logic                 mem_ready;

  // Register controls and status (controller -> pipeline)
  logic                 pc_en;
  logic                 ifid_en;
  logic                 idex_en;
  logic                 exmem_en;
  logic                 memwb_en;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 memwb_bubble;
  logic                 mem_fault;
  state_e               state;
  logic [CNT_W-1:0]     stall_cycles;

  // Pipeline side
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, memwb_bubble, mem_fault, state, stall_cycles
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, memwb_bubble, mem_fault, state, stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_hazard_detect
// Brief   : Combinational load-use detector (load in EX feeding ID operand).
// Revision: 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  output logic                 load_use_o
);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  always_comb begin
    load_use_o = 1'b0;
    if (ex_memread_i && (ex_rd_i != '0)) begin
      load_use_o = (id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                   (id_use_rs2_i && (id_rs2_i == ex_rd_i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush sequencer for the 5-stage pipeline with data-memory
//           watchdog and saturating stall-cycle counter.
// Revision: 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
)(
  input  logic               clock,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  // Wait counter only needs to reach MEM_TIMEOUT-1; it saturates when the
  // watchdog is disabled so a very long stall cannot wrap it.
  localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q,  wait_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  ctrl_t              ctrl;
  logic               load_use;
  logic               mem_stall;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .id_rs1_i     (hz.id_rs1),
    .id_rs2_i     (hz.id_rs2),
    .id_use_rs1_i (hz.id_use_rs1),
    .id_use_rs2_i (hz.id_use_rs2),
    .ex_memread_i (hz.ex_memread),
    .ex_rd_i      (hz.ex_rd),
    .load_use_o   (load_use)
  );

  assign mem_stall = hz.mem_req & ~hz.mem_ready;

  // Next-state and same-cycle controls; priority FAULT > mem stall > branch > load-use
  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        ST_FAULT: begin
          ctrl = CTRL_FAULT;
        end
        default: begin
          if (mem_stall) begin
            // EX is frozen, so branch/load-use will re-present after release
            ctrl    = CTRL_MEMSTALL;
            state_d = ST_MEM_WAIT;
            if (wait_q != WAIT_MAX) begin
              wait_d = wait_q + 1'b1;
            end
            if ((MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT)) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end
          end else begin
            state_d = ST_RUN;
            wait_d  = '0;
            if (hz.branch_taken) begin
              ctrl = CTRL_BRANCH;
            end else if (load_use) begin
              ctrl = CTRL_LOADUSE;
            end
          end
        end
      endcase
    end
  end

  // Stall counter: cycles with the PC held, excluding reset and FAULT
  always_comb begin
    cnt_d = cnt_q;
    if (!reset && (state_q != ST_FAULT) && !ctrl.pc_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, watchdog and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_en        = ctrl.pc_en;
  assign hz.ifid_en      = ctrl.ifid_en;
  assign hz.idex_en      = ctrl.idex_en;
  assign hz.exmem_en     = ctrl.exmem_en;
  assign hz.memwb_en     = ctrl.memwb_en;
  assign hz.ifid_flush   = ctrl.ifid_flush;
  assign hz.idex_flush   = ctrl.idex_flush;
  assign hz.memwb_bubble = ctrl.memwb_bubble;
  assign hz.mem_fault    = fault_q;
  assign hz.state        = state_q;
  assign hz.stall_cycles = cnt_q;

endmodule
`default_nettype wire
